lock_pid_slew: RTL and testbench
================================

// Module: lock_pid_slew
// PURPOSE
//  Output conditioner directly downstream of the lock PID block, between the PID dat_o and the DAC mux.
//  Clamps the PID output to a programmable window and slew-limits it to a set step per tick.
//  Also provides freeze (HOLD) and a controlled ramp to a park value (PARK) for lock/unlock sequencing.
// PARAMETERS
//  DW  14  data width; signed for data ports, unsigned for the step port
//  CW  16  tick-divider counter width
// PORTS
//  clk_i       in   1   clock
//  rstn_i      in   1   reset, asynchronous, active-high (despite the name)
//  dat_i       in   DW  signed PID output (target)
//  en_i        in   1   1 = TRACK (slew-limited), 0 = BYPASS
//  hold_i      in   1   freeze output
//  park_i      in   1   ramp output to park_val_i
//  set_step_i  in   DW  unsigned max |change| per tick; 0 = unlimited
//  set_div_i   in   CW  tick period minus 1 (0 = tick every clock)
//  set_lo_i    in   DW  signed lower clamp
//  set_hi_i    in   DW  signed upper clamp
//  park_val_i  in   DW  signed park target
//  dat_o       out  DW  signed conditioned output (registered)
//  state_o     out  2   0 BYPASS, 1 TRACK, 2 HOLD, 3 PARK
//  lim_o       out  1   target was clamped this cycle
//  busy_o      out  1   output != current target (slewing)
//  int_rst_o   out  1   see CONFIGURATION
// BEHAVIOUR
//  - Reset: dat_o=0, state_o=BYPASS, lim_o=0, busy_o=0, int_rst_o=0, tick counter=0.
//  - State each clock, by priority: park_i->PARK, else hold_i->HOLD, else en_i->TRACK, else BYPASS.
//    State is registered, so a new mode takes effect 1 clock after the inputs change.
//  - Clamp: tgt = min(max(dat_i, set_lo_i), set_hi_i).
//    If set_lo_i > set_hi_i, no clamp is applied (tgt = dat_i) and lim_o=0.
//    lim_o = 1 when tgt != dat_i; registered alongside dat_o.
//  - Tick: counter counts 0..set_div_i, tick asserts when count==set_div_i, then count returns to 0.
//    Counter clears on any state change, so the first tick in a new state comes set_div_i+1 clocks later.
//    If set_div_i is lowered below count, the counter wraps at its next compare miss:
//    count>=set_div_i also ticks.
//  - BYPASS: dat_o <= tgt every clock (latency 1); busy_o=0.
//  - TRACK: on tick, with d = tgt - dat_o (DW+1-bit signed):
//      |d| <= step or step==0 -> dat_o <= tgt;
//      else dat_o <= dat_o + sign(d)*step.
//    step is zero-extended to DW+1 bits. No overflow is possible, since dat_o stays between its old value and tgt.
//    busy_o = (dat_o != tgt).
//  - HOLD: dat_o unchanged; counter held at 0; busy_o=0.
//  - PARK: same as TRACK with target = park_val_i, clamped by the same window.
//    busy_o = 1 until dat_o equals it.
//  - Simultaneous events: priority above decides. Changing dat_i mid-slew retargets on the next tick; no restart.
//  - Reset mid-slew: immediate async return to reset values.
// CONFIGURATION
//  LOCK_SLEW_INTRST_EN defined:
//    - int_rst_o pulses high for exactly 1 clock on the clock where PARK first reaches its target (busy_o 1->0 inside PARK).
//    - Intended to drive the PID int_rst_i so the integrator restarts from int_rst_val on re-lock.
//    - No further pulse while PARK remains settled; a new pulse needs a fresh PARK entry or a target change.
//  LOCK_SLEW_INTRST_EN undefined: int_rst_o is tied to 0 and no edge logic is built.
// TESTING
//  1. BYPASS, lo=-100, hi=100, dat_i=500 -> next clock dat_o=100, lim_o=1; dat_i=-20 -> dat_o=-20, lim_o=0.
//  2. TRACK, step=10, div=0, dat_o=0, dat_i=35, window wide -> dat_o 10,20,30,35 on successive clocks.
//     busy_o falls with the 35.
//  3. TRACK, step=1, div=3, dat_i=-4 from 0 -> one decrement every 4 clocks; dat_o=-4 after 16 clocks.
//  4. Mid-slew hold_i=1 -> dat_o frozen and state_o=2.
//     Release -> slew resumes; first tick set_div_i+1 clocks later.
//  5. park_i=1 and hold_i=1 together, park_val=-50, step=25, dat_o=0 -> state_o=3; dat_o -25 then -50.
//     int_rst_o one-clock pulse on the -50 clock only if LOCK_SLEW_INTRST_EN is defined, else always 0.
//  6. lo=200 > hi=100, dat_i=8000 -> no clamp: dat_o=8000, lim_o=0.
//     Assert rstn_i mid-ramp -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lock_pid_slew_if.sv
// Data, mode and setting signals between the lock PID conditioner and its neighbours.
// The slave modport is the conditioner's side of this interface.
interface lock_pid_slew_if #(
    parameter int DW = 14,
    parameter int CW = 16
);
    logic signed [DW-1:0] dat_i;
    logic                 en_i;
    logic                 hold_i;
    logic                 park_i;
    logic        [DW-1:0] set_step_i;
    logic        [CW-1:0] set_div_i;
    logic signed [DW-1:0] set_lo_i;
    logic signed [DW-1:0] set_hi_i;
    logic signed [DW-1:0] park_val_i;
    logic signed [DW-1:0] dat_o;
    logic        [1:0]    state_o;
    logic                 lim_o;
    logic                 busy_o;
    logic                 int_rst_o;

    modport master (
        output dat_i, en_i, hold_i, park_i, set_step_i, set_div_i,
               set_lo_i, set_hi_i, park_val_i,
        input  dat_o, state_o, lim_o, busy_o, int_rst_o
    );

    modport slave (
        input  dat_i, en_i, hold_i, park_i, set_step_i, set_div_i,
               set_lo_i, set_hi_i, park_val_i,
        output dat_o, state_o, lim_o, busy_o, int_rst_o
    );
endinterface

// File: rtl/lock_pid_slew.sv
// Clamp + slew-limit conditioner between the lock PID output and the DAC mux.
// Optional macro LOCK_SLEW_INTRST_EN adds the integrator-restart pulse on park settle.
module lock_pid_slew #(
    parameter int DW = 14,
    parameter int CW = 16
) (
    input logic clk_i,
    input logic rstn_i,
    lock_pid_slew_if.slave bus
);
    localparam logic [1:0] ST_BYPASS = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_PARK   = 2'd3;

    logic        [1:0]    state_q, state_d;
    logic signed [DW-1:0] dat_q, dat_d, slew_val;
    logic signed [DW-1:0] sel_q, sel_d, tgt_q, tgt_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic                 tick, lim_q, busy_q, busy_d;
    logic signed [DW:0]   diff, nxt_ext;
    logic        [DW:0]   mag, step_x;

    // An inverted window (lo > hi) disables clamping entirely.
    function automatic logic signed [DW-1:0] clamp(
        input logic signed [DW-1:0] v,
        input logic signed [DW-1:0] lo,
        input logic signed [DW-1:0] hi
    );
        logic signed [DW-1:0] r;
        r = v;
        if (lo <= hi) begin
            if (v < lo)      r = lo;
            else if (v > hi) r = hi;
        end
        return r;
    endfunction

    always_comb begin
        if (bus.park_i)      state_d = ST_PARK;
        else if (bus.hold_i) state_d = ST_HOLD;
        else if (bus.en_i)   state_d = ST_TRACK;
        else                 state_d = ST_BYPASS;
    end

    // tgt_q drives this clock's update; tgt_d is what the next mode will chase.
    assign sel_q = (state_q == ST_PARK) ? bus.park_val_i : bus.dat_i;
    assign sel_d = (state_d == ST_PARK) ? bus.park_val_i : bus.dat_i;
    assign tgt_q = clamp(sel_q, bus.set_lo_i, bus.set_hi_i);
    assign tgt_d = clamp(sel_d, bus.set_lo_i, bus.set_hi_i);

    // >= rather than == so a lowered divider wraps instead of counting to 2^CW.
    assign tick = (cnt_q >= bus.set_div_i);

    assign diff   = {tgt_q[DW-1], tgt_q} - {dat_q[DW-1], dat_q};
    assign mag    = diff[DW] ? 0 - diff : diff;
    assign step_x = {1'b0, bus.set_step_i};

    always_comb begin
        nxt_ext = {dat_q[DW-1], dat_q};
        if (diff[DW]) nxt_ext = {dat_q[DW-1], dat_q} - step_x;
        else          nxt_ext = {dat_q[DW-1], dat_q} + step_x;
        if (bus.set_step_i == '0 || mag <= step_x) slew_val = tgt_q;
        else                                       slew_val = nxt_ext[DW-1:0];
    end

    always_comb begin
        dat_d = dat_q;
        cnt_d = '0;
        case (state_q)
            ST_BYPASS: dat_d = tgt_q;
            ST_TRACK, ST_PARK: begin
                if (tick) dat_d = slew_val;
                cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Busy is registered against the mode being entered so it lines up with state_o.
    assign busy_d = ((state_d == ST_TRACK) || (state_d == ST_PARK)) && (dat_d != tgt_d);

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            state_q <= ST_BYPASS;
            dat_q   <= '0;
            cnt_q   <= '0;
            lim_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            lim_q   <= (tgt_q != sel_q);
            busy_q  <= busy_d;
        end
    end

`ifdef LOCK_SLEW_INTRST_EN
    logic ir_q;

    // Fires only on the busy falling edge while parked on both sides of the clock.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) ir_q <= 1'b0;
        else        ir_q <= (state_q == ST_PARK) && (state_d == ST_PARK) && busy_q && !busy_d;
    end

    assign bus.int_rst_o = ir_q;
`else
    assign bus.int_rst_o = 1'b0;
`endif

    assign bus.dat_o   = dat_q;
    assign bus.state_o = state_q;
    assign bus.lim_o   = lim_q;
    assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_lock_pid_slew.sv
// Scoreboard bench for lock_pid_slew: stimulus queues expectations, a negedge monitor checks them.
module tb_lock_pid_slew;
    localparam int DW = 14;
    localparam int CW = 16;

    typedef struct {
        int                   tag;
        logic [8*12-1:0]      nm;
        logic signed [DW-1:0] dat;
        logic [1:0]           st;
        logic                 lim;
        logic                 busy;
        logic                 ir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t me;
    logic ir_settle;

    lock_pid_slew_if #(.DW(DW), .CW(CW)) bus();

    lock_pid_slew #(.DW(DW), .CW(CW)) dut (
        .clk_i (clk),
        .rstn_i(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are presented once per cycle and checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            me = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %0s expectation for cycle %0d never sampled", me.nm, me.tag);
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            me = sb.pop_front();
            checks++;
            if ({bus.dat_o, bus.state_o, bus.lim_o, bus.busy_o, bus.int_rst_o} !==
                {me.dat, me.st, me.lim, me.busy, me.ir}) begin
                errors++;
                $display("FAIL %0s cyc %0d: got dat=%0d st=%0d lim=%0b busy=%0b ir=%0b want dat=%0d st=%0d lim=%0b busy=%0b ir=%0b",
                         me.nm, cyc, bus.dat_o, bus.state_o, bus.lim_o, bus.busy_o, bus.int_rst_o,
                         me.dat, me.st, me.lim, me.busy, me.ir);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [8*12-1:0] nm, input int dat, input int st,
                      input logic lim, input logic busy, input logic ir);
        exp_t e;
        e.tag  = cyc;
        e.nm   = nm;
        e.dat  = DW'(dat);
        e.st   = 2'(st);
        e.lim  = lim;
        e.busy = busy;
        e.ir   = ir;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef LOCK_SLEW_INTRST_EN
        ir_settle = 1'b1;
`else
        ir_settle = 1'b0;
`endif
        bus.dat_i = '0; bus.en_i = 0; bus.hold_i = 0; bus.park_i = 0;
        bus.set_step_i = '0; bus.set_div_i = '0;
        bus.set_lo_i = -14'sd8192; bus.set_hi_i = 14'sd8191; bus.park_val_i = '0;

        step(); step();
        ex("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Bypass with clamp window
        bus.set_lo_i = -14'sd100; bus.set_hi_i = 14'sd100; bus.dat_i = 14'sd500;
        step(); ex("byp_hi", 100, 0, 1, 0, 0);
        bus.dat_i = -14'sd20;
        step(); ex("byp_in", -20, 0, 0, 0, 0);
        bus.dat_i = -14'sd300;
        step(); ex("byp_lo", -100, 0, 1, 0, 0);
        bus.set_lo_i = -14'sd8192; bus.set_hi_i = 14'sd8191; bus.dat_i = '0;
        step(); ex("byp_zero", 0, 0, 0, 0, 0);

        // Track, step 10, tick every clock
        bus.en_i = 1; bus.set_step_i = 14'd10;
        step(); ex("trk_enter", 0, 1, 0, 0, 0);
        bus.dat_i = 14'sd35;
        step(); ex("trk_10", 10, 1, 0, 1, 0);
        step(); ex("trk_20", 20, 1, 0, 1, 0);
        step(); ex("trk_30", 30, 1, 0, 1, 0);
        step(); ex("trk_35", 35, 1, 0, 0, 0);

        // Unlimited step returns to 0, then step 1 every 4 clocks down to -4
        bus.dat_i = '0; bus.set_step_i = '0;
        step(); ex("trk_unlim", 0, 1, 0, 0, 0);
        bus.set_step_i = 14'd1; bus.set_div_i = 16'd3; bus.dat_i = -14'sd4;
        for (int i = 1; i <= 16; i++) begin
            step(); ex("trk_div", -(i / 4), 1, 0, (i < 16), 0);
        end

        // Hold mid-slew, then resume with a fresh divider period
        bus.dat_i = 14'sd4;
        step(); ex("up_1", -4, 1, 0, 1, 0);
        step(); ex("up_2", -4, 1, 0, 1, 0);
        step(); ex("up_3", -4, 1, 0, 1, 0);
        step(); ex("up_4", -3, 1, 0, 1, 0);
        step(); ex("up_5", -3, 1, 0, 1, 0);
        bus.hold_i = 1;
        step(); ex("hold_in", -3, 2, 0, 0, 0);
        step(); ex("hold_a", -3, 2, 0, 0, 0);
        step(); ex("hold_b", -3, 2, 0, 0, 0);
        bus.hold_i = 0;
        step(); ex("rel_0", -3, 1, 0, 1, 0);
        step(); ex("rel_1", -3, 1, 0, 1, 0);
        step(); ex("rel_2", -3, 1, 0, 1, 0);
        step(); ex("rel_3", -3, 1, 0, 1, 0);
        step(); ex("rel_tick", -2, 1, 0, 1, 0);

        // Back to 0, then park (with hold) to -50 at step 25
        bus.set_step_i = '0; bus.set_div_i = '0; bus.dat_i = '0;
        step(); ex("pre_park", 0, 1, 0, 0, 0);
        bus.park_i = 1; bus.hold_i = 1; bus.park_val_i = -14'sd50; bus.set_step_i = 14'd25;
        step(); ex("park_in", 0, 3, 0, 1, 0);
        step(); ex("park_m25", -25, 3, 0, 1, 0);
        step(); ex("park_m50", -50, 3, 0, 0, ir_settle);
        step(); ex("park_stay", -50, 3, 0, 0, 0);
        step(); ex("park_stay2", -50, 3, 0, 0, 0);

        // Inverted window: no clamp
        bus.park_i = 0; bus.hold_i = 0; bus.en_i = 0;
        bus.set_lo_i = 14'sd200; bus.set_hi_i = 14'sd100; bus.dat_i = 14'sd8000;
        step(); ex("park_exit", -50, 0, 0, 0, 0);
        step(); ex("noclamp", 8000, 0, 0, 0, 0);

        // Ramp then async reset between clock edges
        bus.en_i = 1; bus.set_step_i = 14'd10; bus.dat_i = '0;
        step(); ex("rmp_enter", 0, 1, 0, 0, 0);
        bus.dat_i = 14'sd100;
        step(); ex("rmp_10", 10, 1, 0, 1, 0);
        step(); ex("rmp_20", 20, 1, 0, 1, 0);
        step();
        rst = 1'b1;
        #1;
        ex("async_rst", 0, 0, 0, 0, 0);
        step(); ex("rst_held", 0, 0, 0, 0, 0);
        rst = 1'b0;

        step(); step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
